seq_pattern_tx: RTL

//  Moore-style serial pattern transmitter: the sending end of the 1-bit serial

---
 rtl/seq_pattern_tx.sv | 97 +++++++++
 1 files changed

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a latched pattern out MSB-first, count times,
// separated by GAP idle cycles. All outputs are registered from state (Moore).
module seq_pattern_tx #(
    parameter int unsigned PAT_W = 4,
    parameter int unsigned CNT_W = 8,
    parameter int unsigned GAP   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [CNT_W-1:0] count,
    output logic             out,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned IDX_W = $clog2(PAT_W);
    localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(PAT_W - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP,
        S_DONE
    } state_t;

    state_t             state;
    logic [PAT_W-1:0]   pat;
    logic [IDX_W-1:0]   idx;
    logic [CNT_W-1:0]   reps_left;
    logic [GAP_W-1:0]   gap_cnt;

    // Outputs are decoded from the current state, so they trail the state by one edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            pat       <= '0;
            idx       <= '0;
            reps_left <= '0;
            gap_cnt   <= '0;
            out       <= 1'b0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            out   <= 1'b0;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && (count != '0)) begin
                        pat       <= pat_in;
                        reps_left <= count;
                        idx       <= IDX_TOP;
                        state     <= S_SEND;
                    end
                end
                S_SEND: begin
                    out   <= pat[idx];
                    valid <= 1'b1;
                    busy  <= 1'b1;
                    if (idx != '0) begin
                        idx <= idx - IDX_W'(1);
                    end else if (reps_left == CNT_W'(1)) begin
                        state <= S_DONE;
                    end else begin
                        reps_left <= reps_left - CNT_W'(1);
                        idx       <= IDX_TOP;
                        gap_cnt   <= '0;
                        if (GAP > 0) begin
                            state <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    busy <= 1'b1;
                    if (gap_cnt == GAP_LAST) begin
                        state <= S_SEND;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
